// File: rtl/mdu_pkg.sv
// Shared encodings and latency defaults for the E-stage multiply/divide unit.
// Optional madd support is controlled by the MDU_MADD_EN macro.
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MADD  = 4'd4;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result datapath: products, quotients, div-by-zero hold.
// The madd accumulate path exists only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] b_nz;
  logic [31:0] q_m;
  logic [31:0] r_m;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;

  assign b_zero = (b == 32'd0);
  assign b_nz   = b_zero ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly.
  assign mag_a = a[31] ? (32'd0 - a) : a;
  assign mag_b = b[31] ? (32'd0 - b) : b_nz;
  assign q_m   = mag_a / mag_b;
  assign r_m   = mag_a % mag_b;
  assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_m) : q_m;
  assign r_s   = a[31] ? (32'd0 - r_m) : r_m;

  assign q_u = a / b_nz;
  assign r_u = a % b_nz;

  always_comb begin
    {hi_res, lo_res} = prod_s;
    case (op)
      MDU_MULTU: {hi_res, lo_res} = prod_u;
      MDU_DIV: begin
        if (b_zero) {hi_res, lo_res} = {hi, lo};
        else        {hi_res, lo_res} = {r_s, q_s};
      end
      MDU_DIVU: begin
        if (b_zero) {hi_res, lo_res} = {hi, lo};
        else        {hi_res, lo_res} = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      MDU_MADD: {hi_res, lo_res} = {hi, lo} + prod_s;
`endif
      default: {hi_res, lo_res} = prod_s;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU sequencer: FSM, latency counter, result buffers, HI/LO, stall.
// Define MDU_MADD_EN to enable the madd (op 4) accumulate operation.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic        d_mdu_instr,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        load;
  logic        commit;
  logic        mt_en;
  logic [31:0] hi_buf;
  logic [31:0] lo_buf;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  mdu_arith u_arith (
    .op     (mdu_op),
    .a      (src_a),
    .b      (src_b),
    .hi     (hi),
    .lo     (lo),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_n   = is_div(mdu_op) ? DIV_LAT : MULT_LAT;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy  = (state == S_RUN);
  assign stall = d_mdu_instr && (start || busy);
  // mthi/mtlo only land in IDLE and lose to a same-cycle start.
  assign mt_en = (state == S_IDLE) && !start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_buf <= 32'd0;
      lo_buf <= 32'd0;
    end else if (load) begin
      hi_buf <= hi_res;
      lo_buf <= lo_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      hi <= hi_buf;
      lo <= lo_buf;
    end else if (mt_en) begin
      if (hi_write) hi <= src_a;
      if (lo_write) lo <= src_a;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && busy && start)
      $display("mdu_ctrl: start ignored while busy at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, corner sequences, random vs model.
// Build with MDU_MADD_EN defined to exercise madd.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic        d_mdu_instr = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int errors = 0;
  int checks = 0;

  mdu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mdu_op      (mdu_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .d_mdu_instr (d_mdu_instr),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ih;
    logic [31:0] il;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    return (op == 4'd2 || op == 4'd3) ? 10 : 5;
  endfunction

  // Reference: 64-bit integer arithmetic straight from the ISA definition.
  function automatic logic [63:0] model(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] h, input logic [31:0] l);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: res = {32'd0, a} * {32'd0, b};
      4'd2: begin
        if (b == 0) res = {h, l};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd3: res = (b == 0) ? {h, l} : {a % b, a / b};
`ifdef MDU_MADD_EN
      4'd4: res = {h, l} + 64'(sa * sb);
`endif
      default: res = 64'(sa * sb);
    endcase
    return res;
  endfunction

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    src_a = h; hi_write = 1'b1;
    tick();
    hi_write = 1'b0; src_a = l; lo_write = 1'b1;
    tick();
    lo_write = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic dmi,
      input logic hw, input logic [31:0] eh, input logic [31:0] el);
    int nb;
    logic st_ok;
    start = 1'b1; mdu_op = op; src_a = a; src_b = b;
    d_mdu_instr = dmi; hi_write = hw;
    #1;
    st_ok = (stall === dmi);
    tick();
    start = 1'b0; hi_write = 1'b0;
    src_a = $urandom; src_b = $urandom;
    nb = 0;
    while (busy === 1'b1 && nb < 20) begin
      #1;
      if (stall !== dmi) st_ok = 1'b0;
      nb++;
      tick();
    end
    chk({name, " latency"}, 64'(nb), 64'(lat_of(op)));
    chk({name, " stall"}, {63'd0, st_ok}, 64'd1);
    #1;
    chk({name, " stall_after"}, {63'd0, stall}, 64'd0);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, el});
    d_mdu_instr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp;
    logic [31:0] rh;
    logic [31:0] rl;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs.push_back('{4'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
                     32'h00000002, 32'hFFFFFFFA});
    vecs.push_back('{4'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{4'd3, 32'd7, 32'd0, 32'hAAAA5555, 32'h0BADF00D,
                     32'hAAAA5555, 32'h0BADF00D});
    vecs.push_back('{4'd2, 32'd7, 32'd0, 32'h11112222, 32'h33334444,
                     32'h11112222, 32'h33334444});
    vecs.push_back('{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,
                     32'h00000000, 32'h80000000});
    vecs.push_back('{4'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
                     32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{4'd3, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0,
                     32'h0000000F, 32'h0FFFFFFF});
    vecs.push_back('{4'd7, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFA});
`ifdef MDU_MADD_EN
    vecs.push_back('{4'd4, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF,
                     32'h00000001, 32'h00000000});
`else
    vecs.push_back('{4'd4, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF,
                     32'h00000000, 32'h00000001});
`endif

    #1;
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      set_hilo(vecs[i].ih, vecs[i].il);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             1'(i % 2), 1'b0, vecs[i].eh, vecs[i].el);
    end

    // mthi in IDLE: HI next cycle, LO untouched
    set_hilo(32'h0, 32'hCAFEF00D);
    src_a = 32'h12345678; hi_write = 1'b1;
    tick();
    hi_write = 1'b0;
    chk("mthi hi", {32'd0, hi}, 64'h12345678);
    chk("mthi lo", {32'd0, lo}, 64'hCAFEF00D);

    // mthi alongside start: dropped, product committed
    run_op("mthi_start", 4'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1,
           32'hFFFFFFFF, 32'hFFFFFFFA);

    // Async reset partway through a divide
    set_hilo(32'h0000AAAA, 32'h0000BBBB);
    start = 1'b1; mdu_op = 4'd2; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("areset hi", {32'd0, hi}, 64'd0);
    chk("areset lo", {32'd0, lo}, 64'd0);
    chk("areset busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("areset nocommit hi", {32'd0, hi}, 64'd0);
    chk("areset nocommit lo", {32'd0, lo}, 64'd0);
    chk("areset idle", {63'd0, busy}, 64'd0);

    // Random operations against the model
    for (int n = 0; n < 40; n++) begin
      rh  = $urandom;
      rl  = $urandom;
      rop = 4'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) :
             32'($urandom));
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      set_hilo(rh, rl);
      exp = model(rop, ra, rb, rh, rl);
      run_op($sformatf("rnd%0d op%0d", n, rop), rop, ra, rb,
             1'($urandom_range(0, 1)), 1'b0, exp[63:32], exp[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts a start pulse and op code from the decoded E-stage instruction, and computes the result.
- Holds busy for a fixed latency, then commits the result to the architectural HI/LO registers.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- Produces the D-stage stall for any MDU-class instruction that arrives while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd when enabled); legal range 1..15.
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  E-stage instruction is mult/multu/div/divu(/madd); single-cycle pulse.
mdu_op  in  4  0=mult, 1=multu, 2=div, 3=divu, 4=madd (only with the feature enabled); others are treated as mult.
src_a  in  32  forwarded rs value (E stage).
src_b  in  32  forwarded rt value (E stage).
hi_write  in  1  mthi in E stage; writes src_a to HI.
lo_write  in  1  mtlo in E stage; writes src_a to LO.
d_mdu_instr  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo(/madd).
hi  out  32  architectural HI register.
lo  out  32  architectural LO register.
busy  out  1  operation in flight.
stall  out  1  stall request to the hazard unit.

Behaviour:
- Reset values: hi=0, lo=0, busy=0, stall=0, state=IDLE, counter=0, result buffers=0. Reset mid-operation aborts the operation; no commit occurs.
- FSM states: IDLE, RUN.
- IDLE, start=1:
  - Latch the result computed combinationally from src_a/src_b/mdu_op into hi_buf/lo_buf.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - busy=1. Counter decrements every cycle.
  - On the edge where counter==1: hi<=hi_buf, lo<=lo_buf, go to IDLE.
  - Net timing: start in cycle 0, busy high in cycles 1..N, new HI/LO and busy=0 visible in cycle N+1.
- start while in RUN: ignored. This cannot occur under correct stalling; flag it with a simulation-only $display.
- hi_write/lo_write:
  - Take effect at the next edge only in IDLE with start=0.
  - Ignored in RUN (the hazard unit guarantees they are never issued then).
  - If start and hi_write/lo_write are asserted together, start wins and the write is dropped.
- stall = d_mdu_instr && (start || busy). This is combinational, so an MDU instruction directly behind a start is held.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder carrying the dividend's sign. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
- Division by zero (src_b==0): full DIV_CYCLES busy, then hi/lo unchanged; the buffers are loaded with the current hi/lo.
- mfhi/mflo read hi/lo directly. These outputs are always registered values.

Optional Feature:
MDU_MADD_EN:
- Defined: mdu_op=4 (madd) computes {hi_buf,lo_buf} = {hi,lo} + signed(src_a)*signed(src_b) modulo 2^64, with MULT_CYCLES latency. The accumulate uses the HI/LO values at the start cycle.
- Undefined: op 4 decodes as mult, and the adder path is absent.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD;
  - state encodings S_IDLE, S_RUN;
  - default latency constants.
- One sub-module, mdu_arith: purely combinational. Takes op, a, b, hi, lo and returns hi_res/lo_res, including the divide-by-zero hold and the madd path.
- mdu_ctrl keeps the FSM, counter, buffers, HI/LO and stall logic.

Test Plan:
- mult: src_a=0xFFFFFFFE (-2), src_b=3, start 1 cycle -> busy cycles 1-5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div: src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> after 10 cycles hi/lo equal their prior values.
- Hazard: d_mdu_instr=1 in the start cycle and throughout busy -> stall=1 in cycles 0-5 for mult; stall=0 in cycle 6. With d_mdu_instr=0 -> stall=0 always.
- mthi src_a=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged. hi_write together with start -> write dropped, product committed.
- Async reset at cycle 3 of a div -> hi=lo=0 and busy=0 immediately; no commit at cycle 11.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0 after 5 cycles.
